hazard_scoreboard: RTL



---
 rtl/hazard_pkg.sv | 22 ++
 rtl/md_busy_ctr.sv | 42 ++++
 rtl/hazard_scoreboard.sv | 115 +++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// Shared encodings and constants for the D-stage hazard scoreboard.
package hazard_pkg;

  localparam int unsigned T_W_DEFAULT   = 4;
  localparam int unsigned REG_W_DEFAULT = 5;

  localparam logic [1:0] MD_NONE = 2'b00;
  localparam logic [1:0] MD_MULT = 2'b01;
  localparam logic [1:0] MD_DIV  = 2'b10;

  // Tnew as seen in D: cycles until the result can be forwarded.
  localparam logic [T_W_DEFAULT-1:0] TNEW_LOAD = 4'd3;
  localparam logic [T_W_DEFAULT-1:0] TNEW_ALU  = 4'd2;
  localparam logic [T_W_DEFAULT-1:0] TNEW_LINK = 4'd1;

  // Scoreboard entry at the default register and Tnew widths.
  typedef struct packed {
    logic [REG_W_DEFAULT-1:0] dst;
    logic [T_W_DEFAULT-1:0]   tnew;
  } sb_entry_t;

endpackage

// File: rtl/md_busy_ctr.sv
// Busy counter for the multi-cycle mult/div unit; busy for exactly N cycles after a start.
module md_busy_ctr
  import hazard_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       start_i,
  input  logic [1:0] kind_i,
  output logic       busy_o
);

  localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  // The reserved kind loads nothing and lets the counter keep draining.
  always_comb begin
    cnt_d = cnt_q;
    if (start_i && (kind_i == MD_MULT)) begin
      cnt_d = CntW'(MULT_CYCLES);
    end else if (start_i && (kind_i == MD_DIV)) begin
      cnt_d = CntW'(DIV_CYCLES);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign busy_o = (cnt_q != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// D-stage hazard unit: registered (dst, Tnew) scoreboard for stages behind D, producing
// the D stall and forwarding selects, plus HI/LO interlock against the mult/div unit.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int unsigned REG_W       = REG_W_DEFAULT,
  parameter int unsigned T_W         = T_W_DEFAULT,
  parameter int unsigned NUM_STAGES  = 3,
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10,
  localparam int unsigned SelW       = $clog2(NUM_STAGES + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             d_valid_i,
  input  logic [REG_W-1:0] d_rs_i,
  input  logic [REG_W-1:0] d_rt_i,
  input  logic [T_W-1:0]   d_tuse_rs_i,
  input  logic [T_W-1:0]   d_tuse_rt_i,
  input  logic [REG_W-1:0] d_dst_i,
  input  logic [T_W-1:0]   d_tnew_i,
  input  logic             d_md_use_i,
  input  logic [1:0]       d_md_start_i,
  output logic             stall_o,
  output logic [SelW-1:0]  fwd_rs_sel_o,
  output logic [SelW-1:0]  fwd_rt_sel_o,
  output logic             md_busy_o
);

  typedef struct packed {
    logic [REG_W-1:0] dst;
    logic [T_W-1:0]   tnew;
  } entry_t;

  // Index 0 is the E stage (select value 1).
  entry_t [NUM_STAGES-1:0] ent_q, ent_d;

  logic [SelW:0] rs_res, rt_res;
  logic          stall, md_busy, md_stall, md_fire;

  function automatic logic [T_W-1:0] sat_dec(input logic [T_W-1:0] t);
    return (t == '0) ? '0 : t - T_W'(1);
  endfunction

  // Returns {stall, sel}; scanning oldest to youngest lets the youngest match win.
  function automatic logic [SelW:0] lookup(input entry_t [NUM_STAGES-1:0] ents,
                                           input logic [REG_W-1:0]       addr,
                                           input logic [T_W-1:0]         tuse);
    logic            hit;
    logic [SelW-1:0] idx;
    logic [T_W-1:0]  tn;
    hit = 1'b0;
    idx = '0;
    tn  = '0;
    for (int k = int'(NUM_STAGES) - 1; k >= 0; k--) begin
      if ((addr != '0) && (ents[k].dst == addr)) begin
        hit = 1'b1;
        idx = SelW'(k + 1);
        tn  = ents[k].tnew;
      end
    end
    return {hit && (tn > tuse), (hit && (tn == '0)) ? idx : '0};
  endfunction

  always_comb begin
    rs_res   = lookup(ent_q, d_rs_i, d_tuse_rs_i);
    rt_res   = lookup(ent_q, d_rt_i, d_tuse_rt_i);
    md_stall = d_valid_i & d_md_use_i & md_busy;
    stall    = d_valid_i & (rs_res[SelW] | rt_res[SelW] | md_stall);
  end

  assign stall_o      = stall;
  assign fwd_rs_sel_o = rs_res[SelW-1:0];
  assign fwd_rt_sel_o = rt_res[SelW-1:0];

  // A stalled D inserts a bubble into E while older entries keep draining.
  always_comb begin
    ent_d = '0;
    if (!flush_i) begin
      if (d_valid_i && !stall) begin
        ent_d[0].dst  = d_dst_i;
        ent_d[0].tnew = sat_dec(d_tnew_i);
      end
      for (int k = 1; k < int'(NUM_STAGES); k++) begin
        ent_d[k].dst  = ent_q[k-1].dst;
        ent_d[k].tnew = sat_dec(ent_q[k-1].tnew);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ent_q <= '0;
    end else begin
      ent_q <= ent_d;
    end
  end

  assign md_fire = d_valid_i & ~stall & ~flush_i;

  md_busy_ctr #(
    .MULT_CYCLES(MULT_CYCLES),
    .DIV_CYCLES (DIV_CYCLES)
  ) u_md_busy_ctr (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .start_i(md_fire),
    .kind_i (d_md_start_i),
    .busy_o (md_busy)
  );

  assign md_busy_o = md_busy;

endmodule
